// File: rtl/trap_sequencer_pkg.sv
// Shared types for the writeback trap/flush sequencer: exception causes,
// sequencer states and the kind of event being sequenced.
package trap_sequencer_pkg;

  typedef enum logic [3:0] {
    IMISALIGN  = 4'd0,
    IACCESS    = 4'd1,
    IILLEGAL   = 4'd2,
    BREAKPOINT = 4'd3,
    LMISALIGN  = 4'd4,
    LACCESS    = 4'd5,
    SMISALIGN  = 4'd6,
    SACCESS    = 4'd7,
    ECALL_U    = 4'd8,
    ECALL_M    = 4'd11
  } ecause_t;

  typedef enum logic [1:0] {
    TS_IDLE  = 2'd0,
    TS_DRAIN = 2'd1,
    TS_KILL  = 2'd2,
    TS_REDIR = 2'd3
  } trap_state_t;

  typedef enum logic {
    TK_EXC   = 1'b0,
    TK_FLUSH = 1'b1
  } trap_kind_t;

  localparam int unsigned ECAUSE_W = $bits(ecause_t);

  // mcause is the cause code zero-extended to the full CSR width.
  function automatic logic [31:0] cause_to_mcause(input ecause_t c);
    return {{(32 - ECAUSE_W){1'b0}}, c};
  endfunction

endpackage

// File: rtl/trap_sequencer.sv
// Writeback trap/flush sequencer: drains fetch1/memory1 bus activity, kills the
// pipeline, writes mepc/mcause on exceptions and redirects fetch1.
// Optional event counters are built when TRAP_SEQ_COUNT_EN is defined.
//
// state    | meaning
// ---------+----------------------------------------------------------
// TS_IDLE  | waiting for an exception or flush from the write stage
// TS_DRAIN | event captured, waiting for fe1/mem1 busy to clear
// TS_KILL  | one cycle: kill pipeline, CSR strobes (exc), load target
// TS_REDIR | kill held, redirect_valid until fetch1 accepts it
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_core,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic        wb_exc,
  input  ecause_t     wb_exc_cause,
  input  logic        wb_flush,
  input  logic [29:0] wb_pc,
  input  logic        fe1_busy,
  input  logic        mem1_busy,
  input  logic [29:0] csr_mtvec,
  output logic        trap_kill,
  output logic        mepc_we,
  output logic [29:0] mepc_wdata,
  output logic        mcause_we,
  output logic [31:0] mcause_wdata,
  output logic        redirect_valid,
  output logic [29:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        trap_busy
`ifdef TRAP_SEQ_COUNT_EN
  ,
  output logic [31:0] exc_count,
  output logic [31:0] flush_count
`endif
);

  trap_state_t state_q, state_d;
  trap_kind_t  kind_q,  kind_d;
  ecause_t     cause_q, cause_d;
  logic [29:0] pc_q,    pc_d;
  logic [29:0] redir_q, redir_d;
  logic        kill_exc;

  always_ff @(posedge clk_core) begin
    if (reset) begin
      state_q <= TS_IDLE;
      kind_q  <= TK_EXC;
      cause_q <= ecause_t'('0);
      pc_q    <= '0;
      redir_q <= RESET_PC[31:2];
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cause_d = cause_q;
    pc_d    = pc_q;
    redir_d = redir_q;
    unique case (state_q)
      TS_IDLE: begin
        if (wb_exc) begin
          kind_d  = TK_EXC;
          cause_d = wb_exc_cause;
          pc_d    = wb_pc;
          state_d = (fe1_busy || mem1_busy) ? TS_DRAIN : TS_KILL;
        end else if (wb_valid && wb_flush) begin
          kind_d  = TK_FLUSH;
          pc_d    = wb_pc;
          state_d = (fe1_busy || mem1_busy) ? TS_DRAIN : TS_KILL;
        end
      end
      TS_DRAIN: begin
        if (!fe1_busy && !mem1_busy) state_d = TS_KILL;
      end
      TS_KILL: begin
        // Flush resumes at the instruction after the one that asked for it.
        redir_d = (kind_q == TK_EXC) ? csr_mtvec : pc_q + 30'd1;
        state_d = TS_REDIR;
      end
      TS_REDIR: begin
        if (redirect_ready) state_d = TS_IDLE;
      end
      default: state_d = TS_IDLE;
    endcase
  end

  // Reset in the KILL cycle must not leave a half-written trap in the CSRs.
  assign kill_exc = (state_q == TS_KILL) && (kind_q == TK_EXC) && !reset;

  always_comb begin
    trap_kill      = (state_q == TS_KILL) || (state_q == TS_REDIR);
    trap_busy      = (state_q != TS_IDLE);
    redirect_valid = (state_q == TS_REDIR);
    redirect_pc    = redir_q;
    mepc_we        = kill_exc;
    mepc_wdata     = pc_q;
    mcause_we      = kill_exc;
    mcause_wdata   = cause_to_mcause(cause_q);
  end

`ifdef TRAP_SEQ_COUNT_EN
  logic [31:0] exc_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk_core) begin
    if (reset) begin
      exc_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else if (state_q == TS_KILL) begin
      if (kind_q == TK_EXC) exc_cnt_q   <= exc_cnt_q + 32'd1;
      else                  flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign exc_count   = exc_cnt_q;
  assign flush_count = flush_cnt_q;
`endif

endmodule
